coherence_bus_agent: RTL and testbench

- Per-core endpoint of the two-core MSI snooping bus; one instance sits between each L1 cache controller and the shared bus arbiter/forwarder.
- Requester side: accepts one miss or upgrade from the cache, raises the bus request, waits for grant, and drives op/address. It then captures peer data and hit status and returns a one-cycle response.
- Snooper side: answers forwarded peer requests from the local tag/state lookup, supplies data on hit, and issues MSI state downgrades or invalidations.

---
 rtl/coherence_bus_agent.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_coherence_bus_agent.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_agent.sv
// coherence_bus_agent: per-core endpoint of a two-core MSI snooping bus.
// The requester side issues one miss or upgrade to the bus through an
// IDLE/REQ/RESP FSM and returns a one-cycle response. The snooper side
// answers forwarded peer requests from the local tag lookup and posts the
// resulting MSI downgrade or invalidate one cycle later.
// Optional build macro: BUS_AGENT_STATS_EN adds saturating event counters.
module coherence_bus_agent #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // core request side
  input  logic              core_req_valid,
  input  logic [1:0]        core_req_op,
  input  logic [ADDR_W-1:0] core_req_addr,
  output logic              core_req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_peer_hit,
  output logic [1:0]        resp_op,
  // bus requester side
  output logic              req_core,
  input  logic              grant_core,
  output logic [1:0]        bus_operation,
  output logic [ADDR_W-1:0] bus_address,
  input  logic [DATA_W-1:0] bus_data_rd,
  input  logic              bus_hit_rd,
  // bus snooper side
  input  logic              snoop_req,
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic [DATA_W-1:0] snoop_data,
  // local cache lookup and state update
  output logic [ADDR_W-1:0] lkp_addr,
  input  logic              lkp_valid,
  input  logic [1:0]        lkp_state,
  input  logic [DATA_W-1:0] lkp_data,
  output logic              st_we,
  output logic [ADDR_W-1:0] st_addr,
  output logic [1:0]        st_new
`ifdef BUS_AGENT_STATS_EN
  ,
  output logic [31:0]       stat_req_cnt,
  output logic [31:0]       stat_wait_cnt,
  output logic [31:0]       stat_snoop_hit_cnt
`endif
);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_NON  = 2'b11;

  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_S = 2'b01;
  localparam logic [1:0] MSI_M = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t              state_r;
  state_t              state_next_s;

  logic [1:0]          op_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;
  logic                hit_r;

  logic                st_we_r;
  logic [ADDR_W-1:0]   st_addr_r;
  logic [1:0]          st_new_r;

  logic                accept_s;
  logic                granted_s;
  logic                snoop_active_s;
  logic                snoop_hit_s;
  logic                st_write_s;
  logic [1:0]          st_new_s;
  logic                conflict_s;

  // Request acceptance, grant detection and snoop qualification.
  always_comb begin
    accept_s       = (state_r == ST_IDLE) && core_req_valid && (core_req_op != OP_NON);
    granted_s      = (state_r == ST_REQ) && grant_core;
    // While our own request is being granted the bus carries our op, so the
    // forwarded snoop inputs must not be treated as a peer request.
    snoop_active_s = snoop_req && ((snoop_op == OP_RD) || (snoop_op == OP_RDX)) && !granted_s;
    snoop_hit_s    = snoop_active_s && lkp_valid && (lkp_state != MSI_I);
    // A peer BusRdX hitting our pending upgrade means we lost our copy:
    // the upgrade must be reissued as a full BusRdX.
    conflict_s     = (state_r == ST_REQ) && (op_r == OP_UPGR) && snoop_hit_s &&
                     (snoop_op == OP_RDX) && (snoop_addr == addr_r);
  end

  // MSI transition chosen for the snooped line.
  always_comb begin
    st_write_s = 1'b0;
    st_new_s   = MSI_I;
    if (snoop_hit_s) begin
      case (snoop_op)
        OP_RD: begin
          if (lkp_state == MSI_M) begin
            st_write_s = 1'b1;
            st_new_s   = MSI_S;
          end else begin
            st_write_s = 1'b0;
            st_new_s   = MSI_I;
          end
        end
        OP_RDX: begin
          if ((lkp_state == MSI_S) || (lkp_state == MSI_M)) begin
            st_write_s = 1'b1;
            st_new_s   = MSI_I;
          end else begin
            st_write_s = 1'b0;
            st_new_s   = MSI_I;
          end
        end
        default: begin
          st_write_s = 1'b0;
          st_new_s   = MSI_I;
        end
      endcase
    end else begin
      st_write_s = 1'b0;
      st_new_s   = MSI_I;
    end
  end

  // Requester FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Requester FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (grant_core) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Requester FSM outputs, decoded from the current state and latched data.
  always_comb begin
    core_req_ready = 1'b0;
    req_core       = 1'b0;
    bus_operation  = OP_NON;
    bus_address    = '0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    resp_peer_hit  = 1'b0;
    resp_op        = 2'b00;
    case (state_r)
      ST_IDLE: begin
        core_req_ready = 1'b1;
      end
      ST_REQ: begin
        req_core      = 1'b1;
        bus_operation = op_r;
        bus_address   = addr_r;
      end
      ST_RESP: begin
        resp_valid    = 1'b1;
        resp_data     = data_r;
        resp_peer_hit = hit_r;
        resp_op       = op_r;
      end
      default: begin
        core_req_ready = 1'b0;
      end
    endcase
  end

  // Latched request and captured peer response.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= OP_NON;
      addr_r <= '0;
      data_r <= '0;
      hit_r  <= 1'b0;
    end else if (accept_s) begin
      op_r   <= core_req_op;
      addr_r <= core_req_addr;
    end else if (granted_s) begin
      // An upgrade already owns the data, so the bus lines are ignored;
      // a miss only takes data when the peer actually held the line.
      if ((op_r != OP_UPGR) && bus_hit_rd) begin
        data_r <= bus_data_rd;
        hit_r  <= 1'b1;
      end else begin
        data_r <= '0;
        hit_r  <= 1'b0;
      end
    end else if (conflict_s) begin
      op_r <= OP_RDX;
    end
  end

  // Snoop-induced state write, posted one cycle after the hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_we_r   <= 1'b0;
      st_addr_r <= '0;
      st_new_r  <= MSI_I;
    end else begin
      st_we_r   <= st_write_s;
      st_addr_r <= st_write_s ? snoop_addr : '0;
      st_new_r  <= st_write_s ? st_new_s : MSI_I;
    end
  end

  // Snoop response and lookup drive.
  always_comb begin
    lkp_addr   = snoop_addr;
    snoop_hit  = snoop_hit_s;
    snoop_data = snoop_hit_s ? lkp_data : '0;
    st_we      = st_we_r;
    st_addr    = st_addr_r;
    st_new     = st_new_r;
  end

`ifdef BUS_AGENT_STATS_EN
  logic [31:0] stat_req_r;
  logic [31:0] stat_wait_r;
  logic [31:0] stat_hit_r;

  // Saturating event counters for accepted requests, wait cycles and snoop hits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_req_r  <= 32'd0;
      stat_wait_r <= 32'd0;
      stat_hit_r  <= 32'd0;
    end else begin
      if (accept_s && (stat_req_r != 32'hFFFF_FFFF)) begin
        stat_req_r <= stat_req_r + 32'd1;
      end else begin
        stat_req_r <= stat_req_r;
      end
      if ((state_r == ST_REQ) && !grant_core && (stat_wait_r != 32'hFFFF_FFFF)) begin
        stat_wait_r <= stat_wait_r + 32'd1;
      end else begin
        stat_wait_r <= stat_wait_r;
      end
      if (snoop_hit_s && (stat_hit_r != 32'hFFFF_FFFF)) begin
        stat_hit_r <= stat_hit_r + 32'd1;
      end else begin
        stat_hit_r <= stat_hit_r;
      end
    end
  end

  // Counter read ports.
  always_comb begin
    stat_req_cnt       = stat_req_r;
    stat_wait_cnt      = stat_wait_r;
    stat_snoop_hit_cnt = stat_hit_r;
  end
`endif

endmodule

// File: tb/tb_coherence_bus_agent.sv
// Self-checking bench for coherence_bus_agent: table-driven requester and
// snoop vectors, a response scoreboard, and hand-written corner sequences.
module tb_coherence_bus_agent;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req_valid;
  logic [1:0]    core_req_op;
  logic [AW-1:0] core_req_addr;
  logic          core_req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_peer_hit;
  logic [1:0]    resp_op;
  logic          req_core;
  logic          grant_core;
  logic [1:0]    bus_operation;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_data_rd;
  logic          bus_hit_rd;
  logic          snoop_req;
  logic [1:0]    snoop_op;
  logic [AW-1:0] snoop_addr;
  logic          snoop_hit;
  logic [DW-1:0] snoop_data;
  logic [AW-1:0] lkp_addr;
  logic          lkp_valid;
  logic [1:0]    lkp_state;
  logic [DW-1:0] lkp_data;
  logic          st_we;
  logic [AW-1:0] st_addr;
  logic [1:0]    st_new;
`ifdef BUS_AGENT_STATS_EN
  logic [31:0]   stat_req_cnt;
  logic [31:0]   stat_wait_cnt;
  logic [31:0]   stat_snoop_hit_cnt;
`endif

  always #5 clk = ~clk;

  coherence_bus_agent #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_op(core_req_op),
    .core_req_addr(core_req_addr), .core_req_ready(core_req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_peer_hit(resp_peer_hit), .resp_op(resp_op),
    .req_core(req_core), .grant_core(grant_core),
    .bus_operation(bus_operation), .bus_address(bus_address),
    .bus_data_rd(bus_data_rd), .bus_hit_rd(bus_hit_rd),
    .snoop_req(snoop_req), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_data(snoop_data),
    .lkp_addr(lkp_addr), .lkp_valid(lkp_valid), .lkp_state(lkp_state),
    .lkp_data(lkp_data),
    .st_we(st_we), .st_addr(st_addr), .st_new(st_new)
`ifdef BUS_AGENT_STATS_EN
    ,
    .stat_req_cnt(stat_req_cnt), .stat_wait_cnt(stat_wait_cnt),
    .stat_snoop_hit_cnt(stat_snoop_hit_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic          hit;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    int            wait_cycles;
    logic          bhit;
    logic [DW-1:0] bdata;
    logic [1:0]    exp_op;
    logic [DW-1:0] exp_data;
    logic          exp_hit;
  } req_vec_t;

  typedef struct {
    logic          req;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic          valid;
    logic [1:0]    state;
    logic [DW-1:0] data;
    logic          exp_hit;
    logic [DW-1:0] exp_data;
    logic          exp_we;
    logic [1:0]    exp_new;
  } snp_vec_t;

  req_vec_t rv[5];
  snp_vec_t sv[9];

  // Cycle counter: value N during the period that follows posedge N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_op", resp_op, e.op);
        chk("resp_data", resp_data, e.data);
        chk("resp_peer_hit", resp_peer_hit, e.hit);
      end
    end
  end

  task automatic clear_snoop();
    snoop_req  = 1'b0;
    snoop_op   = 2'b00;
    snoop_addr = '0;
    lkp_valid  = 1'b0;
    lkp_state  = 2'b00;
    lkp_data   = '0;
  endtask

  task automatic run_req(input req_vec_t v);
    chk("idle_ready", core_req_ready, 1'b1);
    core_req_valid = 1'b1;
    core_req_op    = v.op;
    core_req_addr  = v.addr;
    bus_hit_rd     = v.bhit;
    bus_data_rd    = v.bdata;
    grant_core     = 1'b0;
    sb.push_back('{v.exp_op, v.exp_data, v.exp_hit, cyc + 2 + v.wait_cycles});
    tick();
    core_req_valid = 1'b0;
    core_req_op    = 2'b00;
    for (int k = 1; k <= v.wait_cycles + 1; k++) begin
      grant_core = (k > v.wait_cycles);
      chk("req_core_high", req_core, 1'b1);
      chk("req_bus_op", bus_operation, v.op);
      chk("req_bus_addr", bus_address, v.addr);
      chk("req_not_ready", core_req_ready, 1'b0);
      tick();
    end
    grant_core = 1'b0;
    chk("resp_req_low", req_core, 1'b0);
    chk("resp_bus_non", bus_operation, 2'b11);
    tick();
    chk("back_idle", core_req_ready, 1'b1);
  endtask

  initial begin
    // requester vectors: op, addr, wait, bus hit, bus data, expected op/data/hit
    rv[0] = '{2'b00, 32'h40,  0, 1'b1, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1'b1};
    rv[1] = '{2'b10, 32'h80,  3, 1'b0, 32'hCAFE0000, 2'b10, 32'h0,        1'b0};
    rv[2] = '{2'b01, 32'h300, 1, 1'b1, 32'h11111111, 2'b01, 32'h0,        1'b0};
    rv[3] = '{2'b00, 32'h44,  2, 1'b1, 32'h0BADF00D, 2'b00, 32'h0BADF00D, 1'b1};
    rv[4] = '{2'b10, 32'h88,  0, 1'b1, 32'hA5A5A5A5, 2'b10, 32'hA5A5A5A5, 1'b1};
    // snoop vectors: req, op, addr, lkp valid/state/data, expected hit/data/we/new
    sv[0] = '{1'b1, 2'b00, 32'h100, 1'b1, 2'b10, 32'h1234, 1'b1, 32'h1234, 1'b1, 2'b01};
    sv[1] = '{1'b1, 2'b10, 32'h100, 1'b1, 2'b01, 32'h55,   1'b1, 32'h55,   1'b1, 2'b00};
    sv[2] = '{1'b1, 2'b00, 32'h104, 1'b1, 2'b01, 32'h66,   1'b1, 32'h66,   1'b0, 2'b00};
    sv[3] = '{1'b1, 2'b10, 32'h108, 1'b1, 2'b10, 32'h77,   1'b1, 32'h77,   1'b1, 2'b00};
    sv[4] = '{1'b1, 2'b00, 32'h10C, 1'b1, 2'b00, 32'h88,   1'b0, 32'h0,    1'b0, 2'b00};
    sv[5] = '{1'b1, 2'b10, 32'h110, 1'b0, 2'b10, 32'h99,   1'b0, 32'h0,    1'b0, 2'b00};
    sv[6] = '{1'b1, 2'b01, 32'h114, 1'b1, 2'b10, 32'hAA,   1'b0, 32'h0,    1'b0, 2'b00};
    sv[7] = '{1'b1, 2'b11, 32'h118, 1'b1, 2'b10, 32'hBB,   1'b0, 32'h0,    1'b0, 2'b00};
    sv[8] = '{1'b0, 2'b00, 32'h11C, 1'b1, 2'b10, 32'hCC,   1'b0, 32'h0,    1'b0, 2'b00};

    reset = 1'b1;
    core_req_valid = 1'b0;
    core_req_op = 2'b00;
    core_req_addr = '0;
    grant_core = 1'b0;
    bus_data_rd = '0;
    bus_hit_rd = 1'b0;
    clear_snoop();
    tick();
    tick();
    chk("rst_ready", core_req_ready, 1'b1);
    chk("rst_req_core", req_core, 1'b0);
    chk("rst_bus_op", bus_operation, 2'b11);
    chk("rst_bus_addr", bus_address, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_op", resp_op, 2'b00);
    chk("rst_st_we", st_we, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_req(rv[i]);

    for (int i = 0; i < 9; i++) begin
      snoop_req  = sv[i].req;
      snoop_op   = sv[i].op;
      snoop_addr = sv[i].addr;
      lkp_valid  = sv[i].valid;
      lkp_state  = sv[i].state;
      lkp_data   = sv[i].data;
      #1;
      chk("lkp_addr", lkp_addr, sv[i].addr);
      chk("snoop_hit", snoop_hit, sv[i].exp_hit);
      chk("snoop_data", snoop_data, sv[i].exp_data);
      tick();
      clear_snoop();
      chk("st_we", st_we, sv[i].exp_we);
      if (sv[i].exp_we) begin
        chk("st_addr", st_addr, sv[i].addr);
        chk("st_new", st_new, sv[i].exp_new);
      end
      tick();
      chk("st_we_one_cycle", st_we, 1'b0);
    end

    // Illegal op is dropped without leaving IDLE.
    core_req_valid = 1'b1;
    core_req_op = 2'b11;
    core_req_addr = 32'h900;
    tick();
    core_req_valid = 1'b0;
    chk("illegal_ready", core_req_ready, 1'b1);
    chk("illegal_req_core", req_core, 1'b0);
    chk("illegal_bus_op", bus_operation, 2'b11);
    tick();
    chk("illegal_still_idle", req_core, 1'b0);

    // Pending upgrade hit by a peer BusRdX to the same line becomes BusRdX.
    core_req_valid = 1'b1;
    core_req_op = 2'b01;
    core_req_addr = 32'h200;
    bus_hit_rd = 1'b1;
    bus_data_rd = 32'h77;
    sb.push_back('{2'b10, 32'h77, 1'b1, cyc + 3});
    tick();
    core_req_valid = 1'b0;
    snoop_req = 1'b1;
    snoop_op = 2'b10;
    snoop_addr = 32'h200;
    lkp_valid = 1'b1;
    lkp_state = 2'b01;
    lkp_data = 32'h99;
    #1;
    chk("conf_snoop_hit", snoop_hit, 1'b1);
    chk("conf_bus_op_before", bus_operation, 2'b01);
    tick();
    clear_snoop();
    chk("conf_bus_op_after", bus_operation, 2'b10);
    chk("conf_st_we", st_we, 1'b1);
    chk("conf_st_new", st_new, 2'b00);
    grant_core = 1'b1;
    tick();
    grant_core = 1'b0;
    tick();

    // Snoop is masked while our own request is being granted.
    core_req_valid = 1'b1;
    core_req_op = 2'b00;
    core_req_addr = 32'h500;
    bus_hit_rd = 1'b0;
    bus_data_rd = 32'h0;
    sb.push_back('{2'b00, 32'h0, 1'b0, cyc + 2});
    tick();
    core_req_valid = 1'b0;
    grant_core = 1'b1;
    snoop_req = 1'b1;
    snoop_op = 2'b00;
    snoop_addr = 32'h600;
    lkp_valid = 1'b1;
    lkp_state = 2'b10;
    lkp_data = 32'h42;
    #1;
    chk("grant_mask_hit", snoop_hit, 1'b0);
    chk("grant_mask_data", snoop_data, 32'h0);
    tick();
    clear_snoop();
    grant_core = 1'b0;
    chk("grant_mask_st_we", st_we, 1'b0);
    tick();

    // Reset in REQ with a concurrent snoop hit.
    core_req_valid = 1'b1;
    core_req_op = 2'b10;
    core_req_addr = 32'h700;
    tick();
    core_req_valid = 1'b0;
    chk("mid_req_core", req_core, 1'b1);
    reset = 1'b1;
    snoop_req = 1'b1;
    snoop_op = 2'b00;
    snoop_addr = 32'h704;
    lkp_valid = 1'b1;
    lkp_state = 2'b10;
    tick();
    reset = 1'b0;
    clear_snoop();
    chk("mrst_req_core", req_core, 1'b0);
    chk("mrst_bus_op", bus_operation, 2'b11);
    chk("mrst_ready", core_req_ready, 1'b1);
    chk("mrst_resp_valid", resp_valid, 1'b0);
    chk("mrst_st_we", st_we, 1'b0);
    tick();
    chk("mrst_idle_req", req_core, 1'b0);
    chk("mrst_idle_resp", resp_valid, 1'b0);
    tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
